pipeline_fetch_queue: RTL
=========================

PIPELINE_FETCH_QUEUE -- requirements
Module: pipeline_fetch_queue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of pc and instruction fields.
REQ-002 SHALL have parameter DEPTH, default 4, queue entries; power of two, >= 2.
REQ-003 SHALL have ports, in order:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  local flush (branch redirect).
- global_flush  in  1  global flush (exception).
- enq_valid  in  1  fetch presents an entry.
- enq_ready  out  1  queue accepts an entry.
- pc_in  in  DATA_WIDTH  fetch pc.
- inst_in  in  DATA_WIDTH  fetched instruction.
- bubble_in  in  1  entry is a bubble.
- deq_valid  out  1  head entry valid.
- deq_ready  in  1  decode accepts head (not stalled).
- pc_out  out  DATA_WIDTH  head pc.
- inst_out  out  DATA_WIDTH  head instruction.
- bubble_out  out  1  head bubble flag.
- count  out  $clog2(DEPTH+1)  occupancy.

Function
REQ-004 SHALL implement a circular FIFO with read/write pointers carrying one extra wrap bit; full = indices equal, wrap bits differ; empty = pointers equal.
REQ-005 SHALL accept an entry on enq_valid && enq_ready; enq_ready = !full, with no combinational dependence on deq_ready.
REQ-006 SHALL retire the head on deq_valid && deq_ready.
REQ-007 SHALL allow enqueue and dequeue in the same cycle; count unchanged.
REQ-008 SHALL wrap pointers modulo DEPTH with no lost or duplicated entry.
REQ-009 SHALL drive pc_out, inst_out, bubble_out to 0 while deq_valid = 0.
REQ-010 SHALL pass bubble_in through unchanged with its entry; bubbles occupy a slot.
REQ-011 SHALL, when flush or global_flush is high, empty the queue at the next edge (pointers equal, count 0), discard any same-cycle enqueue, and block any same-cycle dequeue.
REQ-012 SHALL give flush/global_flush priority over enqueue and dequeue; both flushes behave identically.
REQ-013 SHALL, without bypass, give exactly 1-cycle latency from accepted enqueue to deq_valid on an empty queue.
REQ-014 SHALL hold head outputs stable while deq_valid && !deq_ready.
REQ-015 SHALL keep count = entries stored, range 0..DEPTH.

Reset
REQ-016 SHALL, on rising clk with rst_n = 0, zero both pointers, count and all storage; enq_ready = 1, deq_valid = 0 and head outputs 0 from the following cycle.
REQ-017 SHALL, on reset mid-operation, discard all entries and any same-cycle handshake; reset overrides flush.

Configuration
REQ-018 SHALL honour macro FETCH_QUEUE_BYPASS_EN.
REQ-019 With FETCH_QUEUE_BYPASS_EN defined: when empty and enq_valid, deq_valid = 1 in the same cycle with pc_in/inst_in/bubble_in on the outputs; if deq_ready is also high the entry SHALL NOT be written; flush suppresses the bypass deq_valid.
REQ-020 Without FETCH_QUEUE_BYPASS_EN: deq_valid = !empty; outputs come only from storage (REQ-013).

Structure
REQ-021 SHALL take DATA_BUS and the default queue depth constant FETCH_QUEUE_DEPTH from the shared defines file.
REQ-022 SHALL place storage in sub-module fetch_queue_mem: DEPTH x (2*DATA_WIDTH+1) register array, one synchronous write port, one asynchronous read port.

Verification
REQ-023 Reset: rst_n = 0 with enq_valid = 1 -> next cycle count = 0, enq_ready = 1, deq_valid = 0, pc_out = 0.
REQ-024 Fill: DEPTH = 4, enqueue pc 0x00, 0x04, 0x08, 0x0C with deq_ready = 0 -> count = 4, enq_ready = 0; fifth enqueue 0x10 ignored; draining yields 0x00, 0x04, 0x08, 0x0C in order.
REQ-025 Wrap: 10 cycles of simultaneous enq/deq at count = 2 -> count stays 2, pcs dequeued in order, no gaps.
REQ-026 Flush: count = 3 with enq_valid = 1 (pc 0x40) and flush = 1 -> next cycle count = 0, deq_valid = 0; pc 0x40 never appears.
REQ-027 Stall: deq_ready = 0 for 5 cycles with head pc 0x100, inst 0x2002_0001 -> outputs unchanged all 5 cycles.
REQ-028 Bypass: FETCH_QUEUE_BYPASS_EN defined, empty, enq_valid = 1, pc 0x200, deq_ready = 1 -> same-cycle deq_valid = 1, pc_out = 0x200, count stays 0; undefined -> deq_valid rises one cycle later, count = 1.

Source files
------------

// File: rtl/pipeline_fetch_queue_pkg.sv
// Shared defines for the fetch queue: data bus width, default queue depth
// and the packed entry width helper.
package pipeline_fetch_queue_pkg;

  localparam int DATA_BUS          = 32;
  localparam int FETCH_QUEUE_DEPTH = 4;

  // One entry holds pc, instruction and the bubble flag.
  function automatic int entry_width(input int dw);
    return 2 * dw + 1;
  endfunction

endpackage

// File: rtl/pipeline_fetch_queue_mem.sv
// Fetch queue storage: DEPTH x WIDTH register array, one synchronous write
// port, one asynchronous read port, cleared by synchronous reset.
module fetch_queue_mem #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Clear all entries on reset, otherwise write the addressed entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/pipeline_fetch_queue.sv
// Instruction fetch queue between fetch and decode.
// Circular FIFO with wrap-bit pointers; local and global flush empty it.
// Optional macro FETCH_QUEUE_BYPASS_EN: an entry arriving at an empty queue
// is presented on the head outputs in the same cycle, and is not stored if
// decode takes it immediately.
module pipeline_fetch_queue
  import pipeline_fetch_queue_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_BUS,
  parameter int DEPTH      = FETCH_QUEUE_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       global_flush,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [DATA_WIDTH-1:0]      pc_in,
  input  logic [DATA_WIDTH-1:0]      inst_in,
  input  logic                       bubble_in,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [DATA_WIDTH-1:0]      pc_out,
  output logic [DATA_WIDTH-1:0]      inst_out,
  output logic                       bubble_out,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = entry_width(DATA_WIDTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic          w_flush;
  logic          w_empty;
  logic          w_full;
  logic          w_enq;
  logic          w_deq;
  logic [EW-1:0] w_rdata;
  logic [EW-1:0] w_head;
  logic [AW:0]   w_diff;

  assign w_flush   = flush | global_flush;
  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign enq_ready = !w_full;
  assign w_diff    = r_wptr - r_rptr;
  assign count     = CW'(w_diff);

`ifdef FETCH_QUEUE_BYPASS_EN
  logic w_byp;
  assign w_byp     = w_empty & enq_valid & !w_flush;
  assign deq_valid = !w_empty | w_byp;
  assign w_head    = w_empty ? {pc_in, inst_in, bubble_in} : w_rdata;
  assign w_deq     = !w_empty & deq_ready & !w_flush;
  // A bypassed entry consumed this cycle never occupies a slot.
  assign w_enq     = enq_valid & enq_ready & !w_flush & !(w_byp & deq_ready);
`else
  assign deq_valid = !w_empty;
  assign w_head    = w_rdata;
  assign w_deq     = deq_valid & deq_ready & !w_flush;
  assign w_enq     = enq_valid & enq_ready & !w_flush;
`endif

  assign {pc_out, inst_out, bubble_out} = deq_valid ? w_head : '0;

  // Pointer update: reset, then flush, take priority over the handshakes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (w_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + 1'b1;
      if (w_deq) r_rptr <= r_rptr + 1'b1;
    end
  end

  fetch_queue_mem #(
    .WIDTH(EW),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (w_enq),
    .waddr(r_wptr[AW-1:0]),
    .wdata({pc_in, inst_in, bubble_in}),
    .raddr(r_rptr[AW-1:0]),
    .rdata(w_rdata)
  );

endmodule
